layer2_bank_sched: RTL and testbench
====================================

LAYER2_BANK_SCHED -- requirements
Module: layer2_bank_sched

Interface
REQ-001 Parameter ROWS, default 16, SHALL set the number of 16-word rows written per bank.
REQ-002 Parameter WORDS, default 256, SHALL set the number of words read per bank (ROWS*16).
REQ-003 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 wr_valid  in  1  SHALL mean the producer presents one row.
REQ-006 wr_ready  out  1  SHALL mean the current write bank accepts a row.
REQ-007 wr_bank  out  1  SHALL give the bank index being written.
REQ-008 wr_row  out  4  SHALL give the row index within wr_bank.
REQ-009 rd_valid  out  1  SHALL mean rd_bank/rd_addr are valid for the consumer.
REQ-010 rd_ready  in  1  SHALL mean the consumer takes the current word.
REQ-011 rd_bank  out  1  SHALL give the bank index being read.
REQ-012 rd_addr  out  8  SHALL give the word address within rd_bank.
REQ-013 rd_last  out  1  SHALL mark rd_addr==WORDS-1.
REQ-014 bank_full  out  2  SHALL give one bit per bank, set while the bank is FULL or DRAINING.
REQ-015 ovf_err  out  1  SHALL be a sticky flag for wr_valid&&!wr_ready.

Function
REQ-016 Each bank SHALL hold state EMPTY, FILLING, FULL or DRAINING.
REQ-017 wr_ready SHALL be 1 iff state[wr_bank] is EMPTY or FILLING.
REQ-018 A write accept (wr_valid&&wr_ready) SHALL take bank EMPTY->FILLING and increment wr_row.
REQ-019 An accept with wr_row==ROWS-1 SHALL take bank ->FULL, set wr_row=0 and toggle wr_bank, all on the same edge.
REQ-020 rd_valid SHALL be 1 iff state[rd_bank] is FULL or DRAINING; it SHALL first rise the cycle after that bank turns FULL.
REQ-021 A read accept (rd_valid&&rd_ready) SHALL take bank FULL->DRAINING and increment rd_addr; rd_addr, rd_bank and rd_valid SHALL hold while rd_ready=0.
REQ-022 A read accept with rd_last=1 SHALL take bank ->EMPTY, set rd_addr=0 and toggle rd_bank; wr_ready for that bank SHALL rise the next cycle.
REQ-023 Both banks FULL or DRAINING SHALL force wr_ready=0 (backpressure) with no overwrite.
REQ-024 A same-edge write accept and read accept on opposite banks SHALL both take effect independently.
REQ-025 Counters SHALL wrap only through REQ-019 and REQ-022; no other wrap-around.
REQ-026 ovf_err SHALL set on wr_valid&&!wr_ready and clear only on rst; the offending write SHALL be ignored.

Reset
REQ-027 rst SHALL asynchronously force:
- both banks EMPTY
- wr_bank=0, wr_row=0, rd_bank=0, rd_addr=0
- rd_valid=0, rd_last=0, bank_full=0, ovf_err=0
- wr_ready=1 once rst is released
REQ-028 rst asserted mid-fill or mid-drain SHALL discard all progress; no partial-bank reads SHALL occur after release.

Configuration
REQ-029 With LAYER2_SCHED_PERF_EN defined:
- output stall_cnt[15:0] SHALL count cycles with wr_valid&&!wr_ready.
- stall_cnt SHALL saturate at 16'hFFFF.
- stall_cnt SHALL be cleared by rst.
REQ-030 Without LAYER2_SCHED_PERF_EN, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package layer2_pkg SHALL hold ROWS/WORDS defaults and the bank-state enum (EMPTY, FILLING, FULL, DRAINING).
REQ-032 Sub-module layer2_bank_fsm (per-bank state, inputs wr_done/rd_start/rd_done) SHALL be instantiated twice; pointers and counters SHALL stay in the top.

Verification
REQ-033 rst, then 16 consecutive wr_valid -> wr_row 0..15, wr_bank toggles to 1 after row 15, bank_full=01, rd_valid rises on the next cycle with rd_addr=0.
REQ-034 rd_ready held 1 -> rd_addr 0..255 over 256 cycles, rd_last only at 255, bank_full=00 and rd_bank=1 afterwards.
REQ-035 32 writes with rd_ready=0 -> bank_full=11, wr_ready=0; a 33rd wr_valid sets ovf_err=1, with no state change and stall_cnt=1 when enabled.
REQ-036 Continuous writes plus rd_ready toggling 1010 -> no word skipped or repeated, addresses held on rd_ready=0, and simultaneous opposite-bank accepts both observed.
REQ-037 rst pulse at wr_row=7 and again at rd_addr=100 -> all outputs return to reset values asynchronously, and no rd_valid occurs until 16 new writes complete.

Source files
------------

// File: rtl/layer2_pkg.sv
// Shared defaults and bank-state encoding for the two-bank row-write / word-read scheduler.
package layer2_pkg;

    localparam int ROWS_DEF  = 16;
    localparam int WORDS_DEF = 256;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // A bank owns readable data from the moment it completes until its last word is taken.
    function automatic logic holds_data(bank_state_t s);
        return (s == FULL) || (s == DRAINING);
    endfunction

endpackage

// File: rtl/layer2_bank_fsm.sv
// Per-bank lifecycle EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY; state updates one cycle after the event.
// The caller qualifies every event input with its own handshake, so this block never stalls.
module layer2_bank_fsm
    import layer2_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_start,
    input  logic        wr_done,
    input  logic        rd_start,
    input  logic        rd_done,
    output bank_state_t state
);

    bank_state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // wr_done/rd_done take priority so single-row or single-word banks skip the middle state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (wr_done)       state_d = FULL;
                else if (wr_start) state_d = FILLING;
            end
            FILLING: begin
                if (wr_done) state_d = FULL;
            end
            FULL: begin
                if (rd_done)       state_d = EMPTY;
                else if (rd_start) state_d = DRAINING;
            end
            DRAINING: begin
                if (rd_done) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    assign state = state_q;

endmodule

// File: rtl/layer2_bank_sched.sv
// Ping-pong scheduler: producer fills a bank row by row, consumer drains it word by word; rd_valid follows FULL one cycle later.
// wr_ready drops while the target bank still holds unread data; optional stall counter under LAYER2_SCHED_PERF_EN.
module layer2_bank_sched
    import layer2_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic        wr_bank,
    output logic [3:0]  wr_row,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_bank,
    output logic [7:0]  rd_addr,
    output logic        rd_last,
    output logic [1:0]  bank_full,
`ifdef LAYER2_SCHED_PERF_EN
    output logic [15:0] stall_cnt,
`endif
    output logic        ovf_err
);

    localparam logic [3:0] ROW_LAST  = 4'(ROWS - 1);
    localparam logic [7:0] ADDR_LAST = 8'(WORDS - 1);

    bank_state_t bank_state [2];

    logic       wr_bank_q, wr_bank_d;
    logic [3:0] wr_row_q,  wr_row_d;
    logic       rd_bank_q, rd_bank_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       ovf_q,     ovf_d;
    logic       wr_acc, rd_acc, wr_wrap, rd_wrap;

    assign wr_ready = !holds_data(bank_state[wr_bank_q]);
    assign rd_valid = holds_data(bank_state[rd_bank_q]);
    assign rd_last  = rd_valid && (rd_addr_q == ADDR_LAST);

    assign wr_acc  = wr_valid && wr_ready;
    assign rd_acc  = rd_valid && rd_ready;
    assign wr_wrap = wr_acc && (wr_row_q == ROW_LAST);
    assign rd_wrap = rd_acc && rd_last;

    always_comb begin
        wr_row_d  = wr_row_q;
        wr_bank_d = wr_bank_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        if (wr_wrap) begin
            wr_row_d  = '0;
            wr_bank_d = !wr_bank_q;
        end else if (wr_acc) begin
            wr_row_d  = wr_row_q + 4'd1;
        end
        if (rd_wrap) begin
            rd_addr_d = '0;
            rd_bank_d = !rd_bank_q;
        end else if (rd_acc) begin
            rd_addr_d = rd_addr_q + 8'd1;
        end
        ovf_d = ovf_q || (wr_valid && !wr_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_row_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_addr_q <= '0;
            rd_bank_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_row_q  <= wr_row_d;
            wr_bank_q <= wr_bank_d;
            rd_addr_q <= rd_addr_d;
            rd_bank_q <= rd_bank_d;
            ovf_q     <= ovf_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic sel_wr, sel_rd;
        assign sel_wr = wr_acc && (wr_bank_q == 1'(b));
        assign sel_rd = rd_acc && (rd_bank_q == 1'(b));

        layer2_bank_fsm u_fsm (
            .clk      (clk),
            .rst      (rst),
            .wr_start (sel_wr),
            .wr_done  (sel_wr && wr_wrap),
            .rd_start (sel_rd),
            .rd_done  (sel_rd && rd_wrap),
            .state    (bank_state[b])
        );

        assign bank_full[b] = holds_data(bank_state[b]);
    end

`ifdef LAYER2_SCHED_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (wr_valid && !wr_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign wr_bank = wr_bank_q;
    assign wr_row  = wr_row_q;
    assign rd_bank = rd_bank_q;
    assign rd_addr = rd_addr_q;
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_layer2_bank_sched.sv
// Directed bench for layer2_bank_sched: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_layer2_bank_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic        rd_ready = 1'b0;
    logic        wr_ready, wr_bank, rd_valid, rd_bank, rd_last, ovf_err;
    logic [3:0]  wr_row;
    logic [7:0]  rd_addr;
    logic [1:0]  bank_full;
`ifdef LAYER2_SCHED_PERF_EN
    logic [15:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    layer2_bank_sched dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_bank   (wr_bank),
        .wr_row    (wr_row),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_last   (rd_last),
        .bank_full (bank_full),
`ifdef LAYER2_SCHED_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .ovf_err   (ovf_err)
    );

    // {wr_ready, wr_bank, wr_row, rd_valid, rd_bank, rd_addr, rd_last, bank_full, ovf_err}
    function automatic logic [19:0] status();
        return {wr_ready, wr_bank, wr_row, rd_valid, rd_bank, rd_addr, rd_last, bank_full, ovf_err};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (status() !== {1'b1, 19'd0}) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", status(), {1'b1, 19'd0});
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            #1;
            checks++;
            if ({wr_ready, wr_bank, wr_row, rd_valid, bank_full} !== {1'b1, 1'b0, 4'(i), 1'b0, 2'b00}) begin
                failures++;
                $display("FAIL fill_row%0d got=%b exp=%b", i,
                         {wr_ready, wr_bank, wr_row, rd_valid, bank_full}, {1'b1, 1'b0, 4'(i), 1'b0, 2'b00});
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if (status() !== {1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b01, 1'b0}) begin
            failures++;
            $display("FAIL fill_done got=%h exp=%h", status(),
                     {1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b01, 1'b0});
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            rd_ready = 1'b1;
            #1;
            checks++;
            if ({rd_valid, rd_bank, rd_addr, rd_last, bank_full} !== {1'b1, 1'b0, 8'(i), (i == 255), 2'b01}) begin
                failures++;
                $display("FAIL drain_word%0d got=%b exp=%b", i,
                         {rd_valid, rd_bank, rd_addr, rd_last, bank_full}, {1'b1, 1'b0, 8'(i), (i == 255), 2'b01});
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
        #1;
        checks++;
        if (status() !== {1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 8'd0, 1'b0, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL drain_done got=%h exp=%h", status(),
                     {1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 8'd0, 1'b0, 2'b00, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wr_valid = 1'b1;
            #1;
            checks++;
            if (wr_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_accept%0d got=%b exp=1", i, wr_ready);
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if (status() !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b11, 1'b0}) begin
            failures++;
            $display("FAIL bp_both_full got=%h exp=%h", status(),
                     {1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b11, 1'b0});
        end
        @(negedge clk);
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checks++;
        if (status() !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b11, 1'b1}) begin
            failures++;
            $display("FAIL bp_overflow got=%h exp=%h", status(),
                     {1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0, 1'b0, 2'b11, 1'b1});
        end
`ifdef LAYER2_SCHED_PERF_EN
        checks++;
        if (stall_cnt !== 16'd1) begin
            failures++;
            $display("FAIL bp_stall_cnt got=%0d exp=1", stall_cnt);
        end
`endif
        @(negedge clk);
        #1;
        checks++;
        if (ovf_err !== 1'b1) begin
            failures++;
            $display("FAIL bp_ovf_sticky got=%b exp=1", ovf_err);
        end
    endtask

    // Reference: banks are used strictly in turn, so full_cnt alone decides both handshakes.
    task automatic test_back_to_back();
        logic       m_wb, m_rb;
        logic [3:0] m_row;
        logic [7:0] m_addr;
        int         full_cnt, sims;
        logic       e_wr_rdy, e_rd_vld;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            @(negedge clk);
        end
        m_wb = 1'b1; m_rb = 1'b0; m_row = 4'd0; m_addr = 8'd0; full_cnt = 1; sims = 0;
        for (int i = 0; i < 1023; i++) begin
            e_wr_rdy = (full_cnt < 2);
            e_rd_vld = (full_cnt > 0);
            wr_valid = e_wr_rdy;
            rd_ready = (i % 2 == 0);
            #1;
            checks++;
            if ({wr_ready, wr_bank, wr_row, rd_valid, rd_bank, rd_addr, rd_last} !==
                {e_wr_rdy, m_wb, m_row, e_rd_vld, m_rb, m_addr, (e_rd_vld && m_addr == 8'd255)}) begin
                failures++;
                $display("FAIL b2b_cycle%0d got=%b exp=%b", i,
                         {wr_ready, wr_bank, wr_row, rd_valid, rd_bank, rd_addr, rd_last},
                         {e_wr_rdy, m_wb, m_row, e_rd_vld, m_rb, m_addr, (e_rd_vld && m_addr == 8'd255)});
            end
            if (e_wr_rdy && e_rd_vld && rd_ready) sims++;
            if (e_wr_rdy) begin
                if (m_row == 4'd15) begin
                    m_row = 4'd0; m_wb = !m_wb; full_cnt++;
                end else begin
                    m_row = m_row + 4'd1;
                end
            end
            if (e_rd_vld && rd_ready) begin
                if (m_addr == 8'd255) begin
                    m_addr = 8'd0; m_rb = !m_rb; full_cnt--;
                end else begin
                    m_addr = m_addr + 8'd1;
                end
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        checks++;
        if ({sims, ovf_err} !== {32'd16, 1'b0}) begin
            failures++;
            $display("FAIL b2b_simultaneous got=%0d/%b exp=16/0", sims, ovf_err);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checks++;
        if (wr_row !== 4'd7) begin
            failures++;
            $display("FAIL rstmid_pre_row got=%0d exp=7", wr_row);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (status()[18:0] !== 19'd0) begin
            failures++;
            $display("FAIL rstmid_fill_async got=%h exp=0", status()[18:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_wr_ready got=%b exp=1", wr_ready);
        end
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            rd_ready = 1'b1;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        #1;
        checks++;
        if (rd_addr !== 8'd100) begin
            failures++;
            $display("FAIL rstmid_pre_addr got=%0d exp=100", rd_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (status()[18:0] !== 19'd0) begin
            failures++;
            $display("FAIL rstmid_drain_async got=%h exp=0", status()[18:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1;
            rd_ready = 1'b1;
            #1;
            checks++;
            if ({rd_valid, bank_full, wr_row} !== {1'b0, 2'b00, 4'(i)}) begin
                failures++;
                $display("FAIL rstmid_refill%0d got=%b exp=%b", i, {rd_valid, bank_full, wr_row}, {1'b0, 2'b00, 4'(i)});
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_bank, rd_addr, bank_full} !== {1'b1, 1'b0, 8'd0, 2'b01}) begin
            failures++;
            $display("FAIL rstmid_refilled got=%b exp=%b", {rd_valid, rd_bank, rd_addr, bank_full},
                     {1'b1, 1'b0, 8'd0, 2'b01});
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
